axi_burst_shim: RTL and testbench
=================================

// Module: axi_burst_shim
// PURPOSE
//  Parametrised AXI4 master adapter between cache/PTW request ports and the core AXI port.
//  Generalises the single-transaction shim in four ways:
//   - configurable address, data and ID widths;
//   - AW and W handshakes are decoupled;
//   - up to MaxOutstanding write and read transactions are tracked with credit counters;
//   - requests are back-pressured when credits run out.
//  Sits between the miss handler and the AXI crossbar.
// PARAMETERS
//  AxiAddrWidth   64       address width of rd_addr_i / wr_addr_i
//  AxiDataWidth   64       data width of one beat; strobe width is AxiDataWidth/8
//  AxiIdWidth     4        AXI ID width
//  AxiNumWords    4        maximum burst length in beats; must be >=1
//  MaxOutstanding 4        maximum in-flight transactions per direction; must be >=1
//  axi_req_t      ariane_axi::req_t   AXI request struct type
//  axi_resp_t     ariane_axi::resp_t  AXI response struct type
// PORTS
//  clk_i             in   1                          clock
//  rst_ni            in   1                          reset, asynchronous, active-low
//  clr_i             in   1                          synchronous clear, active-high
//  rd_req_i          in   1                          read request
//  rd_gnt_o          out  1                          AR handshake done
//  rd_addr_i         in   AxiAddrWidth               read address
//  rd_blen_i         in   clog2(AxiNumWords)         read burst length, LEN-1
//  rd_size_i         in   3                          AxSIZE
//  rd_id_i           in   AxiIdWidth                 read ID
//  rd_lock_i         in   1                          exclusive read
//  rd_rdy_i          in   1                          r_ready
//  rd_valid_o        out  1                          R beat valid
//  rd_last_o         out  1                          last R beat
//  rd_data_o         out  AxiDataWidth               R data
//  rd_id_o           out  AxiIdWidth                 R ID
//  rd_exokay_o       out  1                          r.resp == EXOKAY
//  wr_req_i          in   1                          write request
//  wr_gnt_o          out  1                          AW done and last W done
//  wr_addr_i         in   AxiAddrWidth               write address
//  wr_data_i         in   AxiNumWords x AxiDataWidth write data, one word per beat
//  wr_be_i           in   AxiNumWords x AxiDataWidth/8  byte enables, one entry per beat
//  wr_blen_i         in   clog2(AxiNumWords)         write burst length, LEN-1
//  wr_size_i         in   3                          AxSIZE
//  wr_id_i           in   AxiIdWidth                 write ID
//  wr_lock_i         in   1                          exclusive write
//  wr_atop_i         in   6                          AXI5 atomic operation
//  wr_rdy_i          in   1                          b_ready
//  wr_valid_o        out  1                          B valid
//  wr_id_o           out  AxiIdWidth                 B ID
//  wr_exokay_o       out  1                          b.resp == EXOKAY
//  wr_pending_o      out  clog2(MaxOutstanding+1)    writes awaiting B
//  rd_pending_o      out  clog2(MaxOutstanding+1)    reads awaiting the last R beat
//  axi_req_o         out  axi_req_t                  AXI request
//  axi_resp_i        in   axi_resp_t                 AXI response
// BEHAVIOUR
//  Reset / clr_i:
//   - counters, flags and FSM go to zero / IDLE;
//   - all valid and grant outputs are 0;
//   - clr_i mid-burst abandons the burst; the caller must quiesce the bus first.
//  AXI fields:
//   - burst=INCR; prot, cache, qos and region are 0;
//   - addr, len, size, id, lock and atop pass through combinationally.
//  Requester rule: request inputs are held stable from req to gnt.
//  Write FSM, states IDLE and BUSY, with flags aw_done_q and w_done_q:
//   - IDLE & wr_req_i & wr_credit: aw_valid=1 and w_valid=1 in the same cycle, no bubble.
//   - aw_valid is held until aw_ready. w_valid is held until the beat with last has handshaken.
//   - AW may complete before, after, or in the same cycle as any W beat.
//   - Beat counter wr_cnt_q, width max(1, clog2(AxiNumWords)):
//     - w.data = wr_data_i[wr_cnt_q], w.strb = wr_be_i[wr_cnt_q];
//     - w.last = (wr_cnt_q == wr_blen_i);
//     - increments on w_valid & w_ready & !last; cleared on the last beat.
//   - wr_gnt_o pulses for one cycle in the cycle both AW and the last W are done, counting flags or live handshakes.
//   - At wr_gnt_o: return to IDLE, clear the flags, wr_pending += 1.
//   - A single-beat write where AW and W handshake together grants in 0 extra cycles.
//   - No credit (wr_pending == MaxOutstanding): aw_valid and w_valid stay 0 and there is no gnt.
//   - Credit is checked only when leaving IDLE.
//  Write credits:
//   - wr_pending -= 1 on b_valid & b_ready;
//   - grant and B in the same cycle: wr_pending unchanged;
//   - a B with wr_pending == 0 is a protocol error (assertion); the counter saturates at 0.
//  Reads:
//   - ar_valid = rd_req_i & rd_credit; rd_gnt_o = ar_valid & ar_ready.
//   - rd_pending += 1 on AR handshake; -= 1 on r_valid & r_ready & r.last; simultaneous: unchanged.
//   - Atomic writes with wr_atop_i[5]=1 also reserve one read credit at wr_gnt_o, because an R response follows.
//   - If no read credit is available, such an atomic write is stalled in IDLE.
//  R and B paths pass through combinationally with zero latency; the response must be sunk unconditionally.
// STRUCTURE
//  ariane_axi_pkg gets:
//   - ATOP_R_RESP bit index constant;
//   - pending_cnt_t sized clog2(MaxOutstanding+1), provided as a function helper.
//  Sub-module axi_shim_credit_cnt #(MaxOutstanding), instantiated twice:
//   - inputs inc_i, dec_i, clr_i; outputs cnt_o and avail_o;
//   - saturating; inc and dec together hold the count.
// TESTING
//  1. blen=0, aw_ready=w_ready=1 at t0 -> wr_gnt_o at t0, w.last=1, wr_pending 0->1; B at t2 -> 0.
//  2. blen=3, aw_ready low until beat 2 -> beats 0..3 carry wr_data_i[0..3]; last only on beat 3; single wr_gnt_o after AW.
//  3. MaxOutstanding=2, withhold B -> third wr_req_i sees aw_valid=0 and w_valid=0; one B releases it next cycle.
//  4. wr_gnt_o and B in the same cycle at wr_pending=1 -> stays 1. Same for AR handshake with R last on the read side.
//  5. atop=6'b100000 with rd_pending=Max -> write stalls. An R last frees a credit -> write proceeds and rd_pending returns to Max.
//  6. Assert rst_ni low mid-burst at beat 1 -> all valids and grants 0 immediately. After release, a new blen=1 burst starts at beat 0.

Source files
------------

// File: rtl/axi_burst_shim_pkg.sv
// Shared types for the burst shim: AXI channel structs, write FSM states and
// helper constants for the credit counters.
package axi_burst_shim_pkg;

    localparam int unsigned AddrWidth = 64;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned StrbWidth = DataWidth / 8;

    // Atomic operations with this atop bit set also return an R response.
    localparam int unsigned ATOP_R_RESP = 5;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_BUSY = 1'b1
    } wr_state_e;

    // Width of a pending counter that must hold 0..max_out inclusive.
    function automatic int unsigned pending_cnt_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
        logic                 last;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [1:0]         resp;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        logic    b_valid;
        b_chan_t b;
        logic    r_valid;
        r_chan_t r;
    } resp_t;

endpackage

// File: rtl/axi_burst_shim_credit_cnt.sv
// Saturating in-flight transaction counter; inc and dec together hold the count.
module axi_shim_credit_cnt
    import axi_burst_shim_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned CntWidth = pending_cnt_width(MaxOutstanding)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                avail_o
);

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

    logic [CntWidth-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && !dec_i && (cnt_q != CntMax)) begin
            cnt_q <= cnt_q + CntWidth'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    assign cnt_o   = cnt_q;
    assign avail_o = (cnt_q != CntMax);

endmodule

// File: rtl/axi_burst_shim.sv
// AXI4 burst master adapter between the cache/PTW request ports and the core
// AXI port, with decoupled AW/W and credit-limited outstanding transactions.
module axi_burst_shim
    import axi_burst_shim_pkg::*;
#(
    parameter int unsigned AxiAddrWidth   = 64,
    parameter int unsigned AxiDataWidth   = 64,
    parameter int unsigned AxiIdWidth     = 4,
    parameter int unsigned AxiNumWords    = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter type axi_req_t  = axi_burst_shim_pkg::req_t,
    parameter type axi_resp_t = axi_burst_shim_pkg::resp_t,
    localparam int unsigned BlenWidth = (AxiNumWords > 1) ? $clog2(AxiNumWords) : 1,
    localparam int unsigned PendWidth = pending_cnt_width(MaxOutstanding)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic                                          clr_i,
    input  logic                                          rd_req_i,
    output logic                                          rd_gnt_o,
    input  logic [AxiAddrWidth-1:0]                       rd_addr_i,
    input  logic [BlenWidth-1:0]                          rd_blen_i,
    input  logic [2:0]                                    rd_size_i,
    input  logic [AxiIdWidth-1:0]                         rd_id_i,
    input  logic                                          rd_lock_i,
    input  logic                                          rd_rdy_i,
    output logic                                          rd_valid_o,
    output logic                                          rd_last_o,
    output logic [AxiDataWidth-1:0]                       rd_data_o,
    output logic [AxiIdWidth-1:0]                         rd_id_o,
    output logic                                          rd_exokay_o,
    input  logic                                          wr_req_i,
    output logic                                          wr_gnt_o,
    input  logic [AxiAddrWidth-1:0]                       wr_addr_i,
    input  logic [AxiNumWords-1:0][AxiDataWidth-1:0]      wr_data_i,
    input  logic [AxiNumWords-1:0][AxiDataWidth/8-1:0]    wr_be_i,
    input  logic [BlenWidth-1:0]                          wr_blen_i,
    input  logic [2:0]                                    wr_size_i,
    input  logic [AxiIdWidth-1:0]                         wr_id_i,
    input  logic                                          wr_lock_i,
    input  logic [5:0]                                    wr_atop_i,
    input  logic                                          wr_rdy_i,
    output logic                                          wr_valid_o,
    output logic [AxiIdWidth-1:0]                         wr_id_o,
    output logic                                          wr_exokay_o,
    output logic [PendWidth-1:0]                          wr_pending_o,
    output logic [PendWidth-1:0]                          rd_pending_o,
    output axi_req_t                                      axi_req_o,
    input  axi_resp_t                                     axi_resp_i
);

    // Handshakes: a transfer happens in a cycle where valid & ready are both
    // high at the rising edge; once raised, valid and payload hold until then.

    wr_state_e             state_q, state_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic [BlenWidth-1:0]  wr_cnt_q, wr_cnt_d;

    logic                  en;
    logic                  wr_avail, rd_avail;
    logic                  atop_rd;
    logic                  ar_valid, ar_hs;
    logic                  wr_launch, wr_active;
    logic                  aw_valid, w_valid, w_last;
    logic                  aw_hs, w_hs, wr_gnt;
    logic                  b_hs, r_last_hs;

    assign en      = rst_ni & ~clr_i;
    assign atop_rd = wr_atop_i[ATOP_R_RESP];

    // A read-returning atomic write owns the read credit from launch to grant,
    // so AR is held off meanwhile and the two increments never coincide.
    assign ar_valid  = en & rd_req_i & rd_avail & ~((state_q == WR_BUSY) & atop_rd);
    assign ar_hs     = ar_valid & axi_resp_i.ar_ready;
    assign wr_launch = wr_req_i & wr_avail & (~atop_rd | (rd_avail & ~ar_valid));
    assign wr_active = en & ((state_q == WR_BUSY) | wr_launch);

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wr_cnt_d  = wr_cnt_q;
        aw_valid  = wr_active & ~aw_done_q;
        w_valid   = wr_active & ~w_done_q;
        w_last    = (wr_cnt_q == wr_blen_i);
        aw_hs     = aw_valid & axi_resp_i.aw_ready;
        w_hs      = w_valid & axi_resp_i.w_ready;
        wr_gnt    = wr_active & (aw_done_q | aw_hs) & (w_done_q | (w_hs & w_last));
        if (wr_gnt) begin
            state_d   = WR_IDLE;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            wr_cnt_d  = '0;
        end else if (wr_active) begin
            state_d   = WR_BUSY;
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | (w_hs & w_last);
            if (w_hs) begin
                wr_cnt_d = w_last ? '0 : wr_cnt_q + BlenWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= WR_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wr_cnt_q  <= '0;
        end else if (clr_i) begin
            state_q   <= WR_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign b_hs      = axi_resp_i.b_valid & wr_rdy_i;
    assign r_last_hs = axi_resp_i.r_valid & rd_rdy_i & axi_resp_i.r.last;

    axi_shim_credit_cnt #(.MaxOutstanding(MaxOutstanding)) i_wr_credit (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .inc_i   (wr_gnt),
        .dec_i   (b_hs),
        .cnt_o   (wr_pending_o),
        .avail_o (wr_avail)
    );

    axi_shim_credit_cnt #(.MaxOutstanding(MaxOutstanding)) i_rd_credit (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .inc_i   (ar_hs | (wr_gnt & atop_rd)),
        .dec_i   (r_last_hs),
        .cnt_o   (rd_pending_o),
        .avail_o (rd_avail)
    );

    always_comb begin
        axi_req_o           = '0;
        axi_req_o.aw.id     = wr_id_i;
        axi_req_o.aw.addr   = wr_addr_i;
        axi_req_o.aw.len    = 8'(wr_blen_i);
        axi_req_o.aw.size   = wr_size_i;
        axi_req_o.aw.burst  = BURST_INCR;
        axi_req_o.aw.lock   = wr_lock_i;
        axi_req_o.aw.atop   = wr_atop_i;
        axi_req_o.aw_valid  = aw_valid;
        axi_req_o.w.data    = wr_data_i[wr_cnt_q];
        axi_req_o.w.strb    = wr_be_i[wr_cnt_q];
        axi_req_o.w.last    = w_last;
        axi_req_o.w_valid   = w_valid;
        axi_req_o.b_ready   = wr_rdy_i;
        axi_req_o.ar.id     = rd_id_i;
        axi_req_o.ar.addr   = rd_addr_i;
        axi_req_o.ar.len    = 8'(rd_blen_i);
        axi_req_o.ar.size   = rd_size_i;
        axi_req_o.ar.burst  = BURST_INCR;
        axi_req_o.ar.lock   = rd_lock_i;
        axi_req_o.ar_valid  = ar_valid;
        axi_req_o.r_ready   = rd_rdy_i;
    end

    assign wr_gnt_o    = wr_gnt;
    assign rd_gnt_o    = ar_hs;
    assign rd_valid_o  = axi_resp_i.r_valid;
    assign rd_last_o   = axi_resp_i.r.last;
    assign rd_data_o   = axi_resp_i.r.data;
    assign rd_id_o     = axi_resp_i.r.id;
    assign rd_exokay_o = (axi_resp_i.r.resp == RESP_EXOKAY);
    assign wr_valid_o  = axi_resp_i.b_valid;
    assign wr_id_o     = axi_resp_i.b.id;
    assign wr_exokay_o = (axi_resp_i.b.resp == RESP_EXOKAY);

    b_without_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
        b_hs |-> (wr_pending_o != '0));

endmodule

// File: tb/tb_axi_burst_shim.sv
// Directed bench for axi_burst_shim: scoreboards on AW, W, R and B plus
// inline checks on grants, valids and credit counters.
module tb_axi_burst_shim;
    import axi_burst_shim_pkg::*;

    localparam int unsigned NW   = 4;
    localparam int unsigned MAXO = 2;
    localparam int unsigned BW   = 2;
    localparam int unsigned PW   = pending_cnt_width(MAXO);
    localparam int unsigned EW   = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst_n, clr;
    logic                    rd_req, rd_gnt, rd_rdy, rd_valid, rd_last, rd_exokay, rd_lock;
    logic [63:0]             rd_addr, rd_data;
    logic [BW-1:0]           rd_blen, wr_blen;
    logic [2:0]              rd_size, wr_size;
    logic [3:0]              rd_id, rd_id_out, wr_id, wr_id_out;
    logic                    wr_req, wr_gnt, wr_lock, wr_rdy, wr_valid, wr_exokay;
    logic [63:0]             wr_addr;
    logic [NW-1:0][63:0]     wr_data;
    logic [NW-1:0][7:0]      wr_be;
    logic [5:0]              wr_atop;
    logic [PW-1:0]           wr_pending, rd_pending;
    req_t                    axi_req;
    resp_t                   axi_resp;

    logic [EW-1:0] aw_exp_q[$];
    logic [EW-1:0] w_exp_q[$];
    logic [EW-1:0] r_exp_q[$];
    logic [EW-1:0] b_exp_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int gnt_cnt;
    logic gnt_seen;

    axi_burst_shim #(
        .AxiNumWords    (NW),
        .MaxOutstanding (MAXO),
        .axi_req_t      (req_t),
        .axi_resp_t     (resp_t)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clr_i        (clr),
        .rd_req_i     (rd_req),
        .rd_gnt_o     (rd_gnt),
        .rd_addr_i    (rd_addr),
        .rd_blen_i    (rd_blen),
        .rd_size_i    (rd_size),
        .rd_id_i      (rd_id),
        .rd_lock_i    (rd_lock),
        .rd_rdy_i     (rd_rdy),
        .rd_valid_o   (rd_valid),
        .rd_last_o    (rd_last),
        .rd_data_o    (rd_data),
        .rd_id_o      (rd_id_out),
        .rd_exokay_o  (rd_exokay),
        .wr_req_i     (wr_req),
        .wr_gnt_o     (wr_gnt),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .wr_be_i      (wr_be),
        .wr_blen_i    (wr_blen),
        .wr_size_i    (wr_size),
        .wr_id_i      (wr_id),
        .wr_lock_i    (wr_lock),
        .wr_atop_i    (wr_atop),
        .wr_rdy_i     (wr_rdy),
        .wr_valid_o   (wr_valid),
        .wr_id_o      (wr_id_out),
        .wr_exokay_o  (wr_exokay),
        .wr_pending_o (wr_pending),
        .rd_pending_o (rd_pending),
        .axi_req_o    (axi_req),
        .axi_resp_i   (axi_resp)
    );

    task automatic check(input string tag, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input logic [63:0] addr, input logic [BW-1:0] blen, input logic [5:0] atop);
        wr_req  = 1'b1;
        wr_addr = addr;
        wr_blen = blen;
        wr_atop = atop;
        wr_id   = 4'($urandom_range(0, 15));
        wr_size = 3'd3;
        for (int i = 0; i < NW; i++) begin
            wr_data[i] = {$urandom, $urandom};
            wr_be[i]   = 8'($urandom_range(1, 255));
        end
        aw_exp_q.push_back(EW'({wr_id, addr, 8'(blen), 3'd3, BURST_INCR, atop}));
        for (int b = 0; b <= int'(blen); b++)
            w_exp_q.push_back(EW'({wr_data[b], wr_be[b], (b == int'(blen))}));
    endtask

    task automatic drive_b();
        axi_resp.b_valid = 1'b1;
        axi_resp.b.id    = 4'($urandom_range(0, 15));
        axi_resp.b.resp  = ($urandom_range(0, 1) == 1) ? RESP_EXOKAY : RESP_OKAY;
        b_exp_q.push_back(EW'({axi_resp.b.id, axi_resp.b.resp == RESP_EXOKAY}));
    endtask

    task automatic drive_r(input logic last);
        axi_resp.r_valid = 1'b1;
        axi_resp.r.id    = 4'($urandom_range(0, 15));
        axi_resp.r.data  = {$urandom, $urandom};
        axi_resp.r.resp  = ($urandom_range(0, 1) == 1) ? RESP_EXOKAY : RESP_OKAY;
        axi_resp.r.last  = last;
        r_exp_q.push_back(EW'({axi_resp.r.id, axi_resp.r.data, last, axi_resp.r.resp == RESP_EXOKAY}));
    endtask

    task automatic do_b();
        drive_b();
        tick();
        axi_resp.b_valid = 1'b0;
    endtask

    task automatic do_r(input logic last);
        drive_r(last);
        tick();
        axi_resp.r_valid = 1'b0;
    endtask

    task automatic do_single_write(input logic [63:0] addr, input logic [5:0] atop);
        set_write(addr, '0, atop);
        axi_resp.aw_ready = 1'b1;
        axi_resp.w_ready  = 1'b1;
        #1 check("single_wr_gnt", EW'(wr_gnt), EW'(1));
        tick();
        wr_req = 1'b0;
    endtask

    task automatic do_ar();
        rd_req = 1'b1;
        axi_resp.ar_ready = 1'b1;
        rd_id  = 4'($urandom_range(0, 15));
        #1 check("ar_gnt", EW'(rd_gnt), EW'(1));
        tick();
        rd_req = 1'b0;
        axi_resp.ar_ready = 1'b0;
    endtask

    // Monitors sample at the falling edge, where handshake signals are stable.
    logic [EW-1:0] e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (axi_req.aw_valid && axi_resp.aw_ready) begin
                check("aw_q_nonempty", EW'(aw_exp_q.size() != 0), EW'(1));
                if (aw_exp_q.size() != 0) begin
                    e = aw_exp_q.pop_front();
                    check("aw_fields", EW'({axi_req.aw.id, axi_req.aw.addr, axi_req.aw.len,
                          axi_req.aw.size, axi_req.aw.burst, axi_req.aw.atop}), e);
                end
            end
            if (axi_req.w_valid && axi_resp.w_ready) begin
                check("w_q_nonempty", EW'(w_exp_q.size() != 0), EW'(1));
                if (w_exp_q.size() != 0) begin
                    e = w_exp_q.pop_front();
                    check("w_beat", EW'({axi_req.w.data, axi_req.w.strb, axi_req.w.last}), e);
                end
            end
            if (rd_valid && rd_rdy) begin
                check("r_q_nonempty", EW'(r_exp_q.size() != 0), EW'(1));
                if (r_exp_q.size() != 0) begin
                    e = r_exp_q.pop_front();
                    check("r_beat", EW'({rd_id_out, rd_data, rd_last, rd_exokay}), e);
                end
            end
            if (wr_valid && wr_rdy) begin
                check("b_q_nonempty", EW'(b_exp_q.size() != 0), EW'(1));
                if (b_exp_q.size() != 0) begin
                    e = b_exp_q.pop_front();
                    check("b_resp", EW'({wr_id_out, wr_exokay}), e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        rd_req = 1'b1; rd_addr = 64'h1000; rd_blen = '0; rd_size = 3'd3; rd_id = '0; rd_lock = 1'b0;
        rd_rdy = 1'b1; wr_rdy = 1'b1;
        wr_req = 1'b1; wr_addr = '0; wr_data = '0; wr_be = '0; wr_blen = '0; wr_size = 3'd3;
        wr_id = '0; wr_lock = 1'b0; wr_atop = '0;
        axi_resp = '0;
        axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1; axi_resp.ar_ready = 1'b1;

        // Reset state, with requests present to show valids are gated.
        tick(); tick();
        check("rst_aw_valid", EW'(axi_req.aw_valid), EW'(0));
        check("rst_w_valid", EW'(axi_req.w_valid), EW'(0));
        check("rst_ar_valid", EW'(axi_req.ar_valid), EW'(0));
        check("rst_wr_gnt", EW'(wr_gnt), EW'(0));
        check("rst_wr_pend", EW'(wr_pending), EW'(0));
        check("rst_rd_pend", EW'(rd_pending), EW'(0));
        wr_req = 1'b0; rd_req = 1'b0;
        axi_resp.aw_ready = 1'b0; axi_resp.w_ready = 1'b0; axi_resp.ar_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single beat, AW and W together -> same-cycle grant.
        set_write(64'hA000, 2'd0, 6'd0);
        axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
        #1;
        check("t1_gnt", EW'(wr_gnt), EW'(1));
        check("t1_last", EW'(axi_req.w.last), EW'(1));
        check("t1_pend_before", EW'(wr_pending), EW'(0));
        tick();
        wr_req = 1'b0;
        #1 check("t1_pend_after", EW'(wr_pending), EW'(1));
        tick();
        do_b();
        #1 check("t1_pend_b", EW'(wr_pending), EW'(0));

        // 2: four-beat burst, AW accepted only at beat 2.
        set_write(64'hB000, 2'd3, 6'd0);
        axi_resp.w_ready = 1'b1;
        gnt_cnt = 0; gnt_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            axi_resp.aw_ready = (c == 2);
            if (gnt_seen) wr_req = 1'b0;
            #1;
            if (wr_gnt) gnt_cnt++;
            if (c == 3) check("t2_gnt_beat3", EW'(wr_gnt), EW'(1));
            gnt_seen = gnt_seen | wr_gnt;
        end
        tick();
        check("t2_gnt_count", EW'(gnt_cnt), EW'(1));
        check("t2_pend", EW'(wr_pending), EW'(1));
        do_b();

        // 3: credits exhausted -> third write held off until a B returns.
        do_single_write(64'hC000, 6'd0);
        do_single_write(64'hC040, 6'd0);
        #1 check("t3_pend_full", EW'(wr_pending), EW'(MAXO));
        set_write(64'hC080, 2'd0, 6'd0);
        #1;
        check("t3_aw_blocked", EW'(axi_req.aw_valid), EW'(0));
        check("t3_w_blocked", EW'(axi_req.w_valid), EW'(0));
        check("t3_no_gnt", EW'(wr_gnt), EW'(0));
        tick();
        drive_b();
        #1 check("t3_blocked_during_b", EW'(axi_req.aw_valid), EW'(0));
        tick();
        axi_resp.b_valid = 1'b0;
        #1;
        check("t3_aw_released", EW'(axi_req.aw_valid), EW'(1));
        check("t3_w_released", EW'(axi_req.w_valid), EW'(1));
        check("t3_gnt", EW'(wr_gnt), EW'(1));
        tick();
        wr_req = 1'b0;
        #1 check("t3_pend_refull", EW'(wr_pending), EW'(MAXO));
        do_b();
        do_b();
        #1 check("t3_pend_drained", EW'(wr_pending), EW'(0));

        // 4: grant and B together hold the count; same for AR and R last.
        do_single_write(64'hD000, 6'd0);
        set_write(64'hD040, 2'd0, 6'd0);
        drive_b();
        #1 check("t4_gnt_with_b", EW'(wr_gnt), EW'(1));
        tick();
        wr_req = 1'b0; axi_resp.b_valid = 1'b0;
        #1 check("t4_wr_pend_hold", EW'(wr_pending), EW'(1));
        do_b();
        do_ar();
        #1 check("t4_rd_pend_1", EW'(rd_pending), EW'(1));
        rd_req = 1'b1; axi_resp.ar_ready = 1'b1;
        drive_r(1'b1);
        #1 check("t4_ar_with_r", EW'(rd_gnt), EW'(1));
        tick();
        rd_req = 1'b0; axi_resp.ar_ready = 1'b0; axi_resp.r_valid = 1'b0;
        #1 check("t4_rd_pend_hold", EW'(rd_pending), EW'(1));
        do_r(1'b0);
        #1 check("t4_rd_pend_nonlast", EW'(rd_pending), EW'(1));
        do_r(1'b1);
        #1 check("t4_rd_pend_0", EW'(rd_pending), EW'(0));

        // 5: read-returning atomic write needs a read credit.
        do_ar();
        do_ar();
        rd_req = 1'b1; axi_resp.ar_ready = 1'b1;
        #1 check("t5_ar_blocked", EW'(axi_req.ar_valid), EW'(0));
        rd_req = 1'b0; axi_resp.ar_ready = 1'b0;
        set_write(64'hE000, 2'd0, 6'b100000);
        axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
        #1;
        check("t5_atop_stall_aw", EW'(axi_req.aw_valid), EW'(0));
        check("t5_atop_stall_gnt", EW'(wr_gnt), EW'(0));
        tick();
        drive_r(1'b1);
        #1 check("t5_atop_stall_r", EW'(axi_req.aw_valid), EW'(0));
        tick();
        axi_resp.r_valid = 1'b0;
        #1 check("t5_atop_gnt", EW'(wr_gnt), EW'(1));
        tick();
        wr_req = 1'b0;
        #1;
        check("t5_rd_pend_max", EW'(rd_pending), EW'(MAXO));
        check("t5_wr_pend", EW'(wr_pending), EW'(1));
        do_b();
        do_r(1'b1);
        do_r(1'b1);
        #1 check("t5_rd_pend_0", EW'(rd_pending), EW'(0));

        // 6: reset mid-burst, then a fresh two-beat burst starts at beat 0.
        set_write(64'hF000, 2'd3, 6'd0);
        axi_resp.aw_ready = 1'b0; axi_resp.w_ready = 1'b1;
        tick();
        rst_n = 1'b0; rd_req = 1'b1; axi_resp.ar_ready = 1'b1;
        #1;
        check("t6_rst_aw", EW'(axi_req.aw_valid), EW'(0));
        check("t6_rst_w", EW'(axi_req.w_valid), EW'(0));
        check("t6_rst_ar", EW'(axi_req.ar_valid), EW'(0));
        check("t6_rst_wgnt", EW'(wr_gnt), EW'(0));
        check("t6_rst_rgnt", EW'(rd_gnt), EW'(0));
        aw_exp_q.delete();
        w_exp_q.delete();
        wr_req = 1'b0; rd_req = 1'b0; axi_resp.ar_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        set_write(64'hF100, 2'd1, 6'd0);
        axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
        #1;
        check("t6_beat0_data", EW'(axi_req.w.data), EW'(wr_data[0]));
        check("t6_beat0_last", EW'(axi_req.w.last), EW'(0));
        tick();
        #1;
        check("t6_beat1_gnt", EW'(wr_gnt), EW'(1));
        check("t6_beat1_last", EW'(axi_req.w.last), EW'(1));
        tick();
        wr_req = 1'b0;
        #1 check("t6_pend", EW'(wr_pending), EW'(1));

        // Synchronous clear drops outstanding credits.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        #1 check("clr_pend", EW'(wr_pending), EW'(0));

        tick();
        check("aw_q_empty", EW'(aw_exp_q.size()), EW'(0));
        check("w_q_empty", EW'(w_exp_q.size()), EW'(0));
        check("r_q_empty", EW'(r_exp_q.size()), EW'(0));
        check("b_q_empty", EW'(b_exp_q.size()), EW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
